softmax_sum_accum: RTL and testbench

SOFTMAX_SUM_ACCUM -- requirements
Module: softmax_sum_accum

---
 rtl/softmax_sum_accum_pkg.sv | 15 +
 rtl/softmax_sum_accum_bf16_to_fixed.sv | 43 ++++
 rtl/softmax_sum_accum.sv | 110 +++++++++++
 tb/tb_softmax_sum_accum.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/softmax_sum_accum_pkg.sv
// Shared definitions for the softmax denominator accumulator: BF16 field layout,
// exponent bias and FSM state encoding.
package softmax_sum_accum_pkg;

   localparam int BF16_EXP_W = 8;
   localparam int BF16_MAN_W = 7;
   localparam logic [BF16_EXP_W-1:0] BF16_BIAS = 8'd127;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/softmax_sum_accum_bf16_to_fixed.sv
// Combinational BF16 -> unsigned Q1.FRAC_BITS conversion for values nominally in [0, 1.0];
// out-of-range inputs are clamped to 0 or 1.0 and flagged.
module bf16_to_fixed
   import softmax_sum_accum_pkg::*;
#(
   parameter int FRAC_BITS = 16
) (
   input  logic [15:0]        bf16,
   output logic [FRAC_BITS:0] value,
   output logic               clip
);

   logic                  sign;
   logic [BF16_EXP_W-1:0] expo;
   logic [BF16_MAN_W-1:0] man;
   logic [FRAC_BITS:0]    mag;
   logic [BF16_EXP_W-1:0] shamt;

   assign sign  = bf16[15];
   assign expo  = bf16[14:7];
   assign man   = bf16[6:0];
   // 1.M aligned so that the hidden one lands on the integer bit
   assign mag   = {{(FRAC_BITS-BF16_MAN_W){1'b0}}, 1'b1, man} << (FRAC_BITS - BF16_MAN_W);
   assign shamt = BF16_BIAS - expo;

   always_comb begin
      value = '0;
      clip  = 1'b0;
      if (expo == '0) begin
         value = '0;
      end else if (sign) begin
         clip = 1'b1;
      end else if (expo > BF16_BIAS || (expo == BF16_BIAS && man != '0)) begin
         value[FRAC_BITS] = 1'b1;
         clip             = 1'b1;
      end else if (expo == BF16_BIAS) begin
         value[FRAC_BITS] = 1'b1;
      end else begin
         value = mag >> shamt;
      end
   end

endmodule

// File: rtl/softmax_sum_accum.sv
// Sums a stream of BF16 exponentials into a fixed-point softmax denominator per vector.
// Build option: define SOFTMAX_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module softmax_sum_accum
   import softmax_sum_accum_pkg::*;
#(
   parameter int FRAC_BITS = 16,
   parameter int ACC_WIDTH = 32,
   parameter int CNT_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_clip
);

   state_t                 state, state_nxt;
   logic                   drain_ph;
   logic                   beat_xfer, res_xfer;
   logic [FRAC_BITS:0]     conv_val, s1_val;
   logic                   conv_clip, s1_clip, s1_vld;
   logic [ACC_WIDTH-1:0]   acc, acc_nxt;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   clip_q;

   bf16_to_fixed #(.FRAC_BITS(FRAC_BITS)) u_conv (
      .bf16  (in_data),
      .value (conv_val),
      .clip  (conv_clip)
   );

   assign beat_xfer = in_valid && in_ready;
   assign res_xfer  = out_valid && out_ready;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (drain_ph) state_nxt = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_ACCUM;
         end
         default: state_nxt = ST_ACCUM;
      endcase
   end

   // drain_ph marks the second DRAIN cycle, when the last beat has reached the accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_ACCUM;
         drain_ph <= 1'b0;
      end else begin
         state    <= state_nxt;
         drain_ph <= (state == ST_DRAIN) && !drain_ph;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_val  <= '0;
         s1_clip <= 1'b0;
      end else begin
         s1_vld  <= beat_xfer;
         s1_val  <= conv_val;
         s1_clip <= conv_clip;
      end
   end

`ifdef SOFTMAX_ACC_SAT_EN
   logic [ACC_WIDTH:0] acc_wide;
   assign acc_wide = {1'b0, acc} + {{(ACC_WIDTH-FRAC_BITS){1'b0}}, s1_val};
   assign acc_nxt  = acc_wide[ACC_WIDTH] ? '1 : acc_wide[ACC_WIDTH-1:0];
`else
   assign acc_nxt  = acc + {{(ACC_WIDTH-FRAC_BITS-1){1'b0}}, s1_val};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         cnt    <= '0;
         clip_q <= 1'b0;
      end else if (res_xfer) begin
         acc    <= '0;
         cnt    <= '0;
         clip_q <= 1'b0;
      end else if (s1_vld) begin
         acc    <= acc_nxt;
         cnt    <= cnt + 1'b1;
         clip_q <= clip_q | s1_clip;
      end
   end

   assign out_sum   = acc;
   assign out_count = cnt;
   assign out_clip  = clip_q;

endmodule

// File: tb/tb_softmax_sum_accum.sv
// Randomized bench: two instances (32-bit and 20-bit accumulators) checked against a real-arithmetic model.
module tb_softmax_sum_accum;

   localparam int FRAC = 16;
   localparam int AW_A = 32, CW_A = 12;
   localparam int AW_B = 20, CW_B = 5;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic a_in_ready, a_out_valid, a_out_clip, b_in_ready, b_out_valid, b_out_clip;
   logic [AW_A-1:0] a_out_sum;
   logic [CW_A-1:0] a_out_count;
   logic [AW_B-1:0] b_out_sum;
   logic [CW_B-1:0] b_out_count;

   int total = 0, bad = 0;

   always #5 clk = ~clk;

   softmax_sum_accum #(.FRAC_BITS(FRAC), .ACC_WIDTH(AW_A), .CNT_WIDTH(CW_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
      .out_count(a_out_count), .out_clip(a_out_clip));

   softmax_sum_accum #(.FRAC_BITS(FRAC), .ACC_WIDTH(AW_B), .CNT_WIDTH(CW_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
      .out_count(b_out_count), .out_clip(b_out_clip));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // value of a BF16 number in [0,1] scaled by 2^FRAC, truncated toward zero
   function automatic longint unsigned ref_conv(input logic [15:0] b, output bit c);
      int  e;
      int  m;
      real r;
      e = int'(b[14:7]);
      m = int'(b[6:0]);
      c = 1'b0;
      if (e == 0) return 0;
      if (b[15]) begin c = 1'b1; return 0; end
      if (e > 127 || (e == 127 && m != 0)) begin c = 1'b1; return 64'd1 << FRAC; end
      r = (128.0 + real'(m)) / 128.0 * (2.0 ** real'(e - 127)) * (2.0 ** real'(FRAC));
      return longint'($rtoi(r));
   endfunction

   function automatic longint unsigned fit(input longint unsigned s, input int w);
      longint unsigned lim;
      lim = (64'd1 << w);
`ifdef SOFTMAX_ACC_SAT_EN
      return (s >= lim) ? lim - 1 : s;
`else
      return s % lim;
`endif
   endfunction

   task automatic check_result(input string tag, input longint unsigned sum, input int n, input bit c);
      chk({tag, ".a_sum"},   64'(a_out_sum),   fit(sum, AW_A));
      chk({tag, ".a_count"}, 64'(a_out_count), 64'(n % (1 << CW_A)));
      chk({tag, ".a_clip"},  64'(a_out_clip),  64'(c));
      chk({tag, ".b_sum"},   64'(b_out_sum),   fit(sum, AW_B));
      chk({tag, ".b_count"}, 64'(b_out_count), 64'(n % (1 << CW_B)));
      chk({tag, ".b_clip"},  64'(b_out_clip),  64'(c));
      chk({tag, ".in_ready_done"}, 64'({a_in_ready, b_in_ready}), 64'd0);
   endtask

   task automatic run_vector(input string tag, input logic [15:0] beats[$], input int gap_max, input int hold);
      longint unsigned sum;
      bit c, cb;
      sum = 0;
      c   = 1'b0;
      foreach (beats[i]) begin
         sum += ref_conv(beats[i], cb);
         c |= cb;
      end
      foreach (beats[i]) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'(($urandom));
            in_last  = 1'($urandom);
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = beats[i];
         in_last  = (i == beats.size() - 1);
         if (i == 0) chk({tag, ".in_ready_accum"}, 64'({a_in_ready, b_in_ready}), 64'd3);
         @(posedge clk);
      end
      #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = (hold == 0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("%s.valid_c%0d", tag, k), 64'({a_out_valid, b_out_valid}), (k == 3) ? 64'd3 : 64'd0);
      end
      check_result(tag, sum, beats.size(), c);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk({tag, ".valid_held"}, 64'({a_out_valid, b_out_valid}), 64'd3);
         check_result({tag, ".held"}, sum, beats.size(), c);
         out_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".valid_after"},    64'({a_out_valid, b_out_valid}), 64'd0);
      chk({tag, ".in_ready_after"}, 64'({a_in_ready, b_in_ready}), 64'd3);
      chk({tag, ".sum_cleared"},    64'(a_out_sum), 64'd0);
      out_ready = 1'b0;
   endtask

   function automatic logic [15:0] rand_beat();
      case ($urandom_range(0, 9))
         0:       return 16'h3F80;
         1:       return 16'h0000;
         2:       return {1'b1, 8'($urandom_range(1, 255)), 7'($urandom)};
         3:       return {1'b0, 8'($urandom_range(127, 255)), 7'($urandom)};
         default: return {1'b0, 8'($urandom_range(100, 126)), 7'($urandom)};
      endcase
   endfunction

   initial begin
      logic [15:0] v[$];
      #2;
      chk("rst.valid",    64'({a_out_valid, b_out_valid}), 64'd0);
      chk("rst.sum",      64'(a_out_sum), 64'd0);
      chk("rst.count",    64'(a_out_count), 64'd0);
      chk("rst.clip",     64'(a_out_clip), 64'd0);
      chk("rst.in_ready", 64'({a_in_ready, b_in_ready}), 64'd3);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      v = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
      run_vector("four_ones", v, 0, 0);
      v = '{16'h3F00, 16'h3E80, 16'h0000, 16'h3700};
      run_vector("fractions", v, 0, 0);
      v = '{16'hBF80, 16'h4000};
      run_vector("clipped", v, 1, 2);
      v = '{16'h3F80};
      run_vector("held_done", v, 0, 5);
      v = {};
      repeat (16) v.push_back(16'h3F80);
      run_vector("sixteen_ones", v, 0, 0);
      v = {};
      repeat (33) v.push_back(16'h3F00);
      run_vector("count_wrap", v, 0, 1);

      // reset in the middle of a vector discards it
      v = '{16'h3F80, 16'h3F80};
      foreach (v[i]) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = v[i];
         in_last  = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midrst.valid",    64'({a_out_valid, b_out_valid}), 64'd0);
      chk("midrst.sum",      64'(a_out_sum), 64'd0);
      chk("midrst.count",    64'(a_out_count), 64'd0);
      chk("midrst.in_ready", 64'({a_in_ready, b_in_ready}), 64'd3);
      @(negedge clk);
      rst_n = 1'b1;
      v = '{16'h3F80};
      run_vector("after_rst", v, 0, 0);

      for (int t = 0; t < 25; t++) begin
         v = {};
         repeat ($urandom_range(1, 7)) v.push_back(rand_beat());
         run_vector($sformatf("rnd%0d", t), v, 3, $urandom_range(0, 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
